// File: rtl/mycpu_pkg.sv
// Shared types for the myCPU decode-stage bypass scoreboard.
// Entry fields are sized to fixed maxima so one typedef serves every AW/STAGES choice.
package mycpu_pkg;
    localparam int AW_DEF     = 5;
    localparam int DW_DEF     = 32;
    localparam int ADDR_MAX_W = 8;
    localparam int LAT_MAX_W  = 8;

    localparam logic [ADDR_MAX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                  v;
        logic [ADDR_MAX_W-1:0] addr;
        logic [LAT_MAX_W-1:0]  lat;
    } bypass_entry_t;
endpackage

// File: rtl/mycpu_bypass_lookup.sv
// Single-source priority matcher: the youngest valid entry holding i_addr wins.
module mycpu_bypass_lookup
    import mycpu_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int SW     = 2
) (
    input  bypass_entry_t [STAGES-1:0] i_ent,
    input  logic [ADDR_MAX_W-1:0]      i_addr,
    output logic                       o_match,
    output logic                       o_ready,
    output logic [SW-1:0]              o_sel
);
    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        o_match = 1'b0;
        o_ready = 1'b0;
        o_sel   = '0;
        for (int k = STAGES-1; k >= 0; k--) begin
            if (i_ent[k].v && (i_ent[k].addr == i_addr)) begin
                o_match = 1'b1;
                o_sel   = SW'(k);
                o_ready = (k >= int'(i_ent[k].lat));
            end
        end
    end
endmodule

// File: rtl/mycpu_bypass_scoreboard.sv
// Hazard/bypass scoreboard: tracks in-flight writes across STAGES post-ID stages,
// forwards the newest ready result per source and stalls ID on unready producers.
module mycpu_bypass_scoreboard
    import mycpu_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int STAGES = 3,
    parameter int NSRC   = 2,
    parameter int LW     = $clog2(STAGES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_used,
    input  logic [AW-1:0]        id_dst_addr,
    input  logic                 id_dst_wen,
    input  logic [LW-1:0]        id_dst_lat,
    input  logic                 pipe_adv,
    input  logic [STAGES-1:0]    flush_mask,
    input  logic [STAGES*DW-1:0] stage_data,
    input  logic [NSRC*DW-1:0]   rf_data,
    output logic [NSRC*DW-1:0]   src_data,
    output logic [NSRC-1:0]      fwd_hit,
    output logic                 stall,
    output logic                 issue,
    output logic [31:0]          stall_cnt
);
    localparam int SW = (STAGES > 1) ? $clog2(STAGES) : 1;

    bypass_entry_t [STAGES-1:0]   r_ent;
    bypass_entry_t [STAGES-1:0]   w_ent_nxt;
    bypass_entry_t                w_new;
    logic [LAT_MAX_W-1:0]         w_lat_clamp;
    logic [STAGES-1:0][DW-1:0]    w_stage;
    logic [NSRC-1:0]              w_hazard;
    logic [31:0]                  r_stall_cnt;

    assign w_stage = stage_data;

    always_comb begin
        if (int'(id_dst_lat) > STAGES-1) w_lat_clamp = LAT_MAX_W'(STAGES-1);
        else                             w_lat_clamp = LAT_MAX_W'(id_dst_lat);
    end

    // Writes to r0 are architecturally dropped, so they never become producers.
    always_comb begin
        w_new      = '0;
        w_new.addr = ADDR_MAX_W'(id_dst_addr);
        w_new.lat  = w_lat_clamp;
        w_new.v    = issue & id_dst_wen & (w_new.addr != REG_ZERO);
    end

    // Shift on advance, then flush whatever lands in each slot.
    always_comb begin
        w_ent_nxt = r_ent;
        if (pipe_adv) begin
            for (int k = STAGES-1; k >= 1; k--) w_ent_nxt[k] = r_ent[k-1];
            w_ent_nxt[0] = w_new;
        end
        for (int k = 0; k < STAGES; k++) begin
            if (flush_mask[k]) w_ent_nxt[k].v = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_ent <= '0;
        else     r_ent <= w_ent_nxt;
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [ADDR_MAX_W-1:0] w_addr;
        logic                  w_active;
        logic                  w_match;
        logic                  w_ready;
        logic [SW-1:0]         w_sel;

        assign w_addr   = ADDR_MAX_W'(id_src_addr[i*AW +: AW]);
        assign w_active = id_src_used[i] & (w_addr != REG_ZERO);

        mycpu_bypass_lookup #(
            .STAGES (STAGES),
            .SW     (SW)
        ) u_lookup (
            .i_ent   (r_ent),
            .i_addr  (w_addr),
            .o_match (w_match),
            .o_ready (w_ready),
            .o_sel   (w_sel)
        );

        assign w_hazard[i] = w_active & w_match & ~w_ready;
        assign fwd_hit[i]  = w_active & w_match & w_ready;

        always_comb begin
            src_data[i*DW +: DW] = '0;
            if (w_active) begin
                if (!w_match)     src_data[i*DW +: DW] = rf_data[i*DW +: DW];
                else if (w_ready) src_data[i*DW +: DW] = w_stage[w_sel];
            end
        end
    end

    assign stall = id_valid & (|w_hazard);
    assign issue = id_valid & ~stall & pipe_adv;

    always_ff @(posedge clk) begin
        if (rst)        r_stall_cnt <= '0;
        else if (stall) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_mycpu_bypass_scoreboard.sv
// Directed bench for the bypass scoreboard: a per-cycle vector table plus
// hand-written hold/reset and latency-clamp sequences.
module tb_mycpu_bypass_scoreboard;
    logic         clk;
    logic         rst;
    logic         id_valid;
    logic [9:0]   id_src_addr;
    logic [1:0]   id_src_used;
    logic [4:0]   id_dst_addr;
    logic         id_dst_wen;
    logic [1:0]   id_dst_lat;
    logic         pipe_adv;
    logic [2:0]   flush_mask;
    logic [95:0]  stage_data;
    logic [63:0]  rf_data;
    logic [63:0]  src_data;
    logic [1:0]   fwd_hit;
    logic         stall;
    logic         issue;
    logic [31:0]  stall_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [31:0] RF0 = 32'h1000;
    localparam logic [31:0] RF1 = 32'h2000;

    mycpu_bypass_scoreboard #(.AW(5), .DW(32), .STAGES(3), .NSRC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_src_addr (id_src_addr),
        .id_src_used (id_src_used),
        .id_dst_addr (id_dst_addr),
        .id_dst_wen  (id_dst_wen),
        .id_dst_lat  (id_dst_lat),
        .pipe_adv    (pipe_adv),
        .flush_mask  (flush_mask),
        .stage_data  (stage_data),
        .rf_data     (rf_data),
        .src_data    (src_data),
        .fwd_hit     (fwd_hit),
        .stall       (stall),
        .issue       (issue),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        vld, adv;
        logic [2:0]  fl;
        logic [1:0]  used;
        logic [4:0]  s0, s1, dst;
        logic        wen;
        logic [1:0]  lat;
        logic [31:0] sd0, sd1, sd2;
        logic        e_stall, e_issue;
        logic [1:0]  e_hit;
        logic [31:0] e_o0, e_o1, e_cnt;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(string name, logic vld, logic adv, logic [2:0] fl,
                                logic [1:0] used, logic [4:0] s0, logic [4:0] s1,
                                logic [4:0] dst, logic wen, logic [1:0] lat,
                                logic [31:0] sd0, logic [31:0] sd1, logic [31:0] sd2,
                                logic e_stall, logic e_issue, logic [1:0] e_hit,
                                logic [31:0] e_o0, logic [31:0] e_o1, logic [31:0] e_cnt);
        vec_t v;
        v.name = name; v.vld = vld; v.adv = adv; v.fl = fl; v.used = used;
        v.s0 = s0; v.s1 = s1; v.dst = dst; v.wen = wen; v.lat = lat;
        v.sd0 = sd0; v.sd1 = sd1; v.sd2 = sd2;
        v.e_stall = e_stall; v.e_issue = e_issue; v.e_hit = e_hit;
        v.e_o0 = e_o0; v.e_o1 = e_o1; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic adv, input logic [2:0] fl,
                         input logic [1:0] used, input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] dst, input logic wen, input logic [1:0] lat,
                         input logic [31:0] sd0, input logic [31:0] sd1, input logic [31:0] sd2);
        id_valid    = vld;
        pipe_adv    = adv;
        flush_mask  = fl;
        id_src_used = used;
        id_src_addr = {s1, s0};
        id_dst_addr = dst;
        id_dst_wen  = wen;
        id_dst_lat  = lat;
        stage_data  = {sd2, sd1, sd0};
        rf_data     = {RF1, RF0};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300);
        next_cycle();
        next_cycle();
        rst = 1'b0;

        vecs[0]  = mk("reset",      1, 1, 3'b000, 2'b11, 1, 2, 0, 0, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b00, RF0,      RF1,      0);
        vecs[1]  = mk("alu_prod",   1, 1, 3'b000, 2'b11, 1, 2, 3, 1, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b00, RF0,      RF1,      0);
        vecs[2]  = mk("alu_use",    1, 1, 3'b000, 2'b11, 3, 2, 0, 0, 0, 32'h11,  32'h200, 32'h300, 0, 1, 2'b01, 32'h11,   RF1,      0);
        vecs[3]  = mk("load_prod",  1, 1, 3'b000, 2'b01, 3, 0, 5, 1, 1, 32'h100, 32'h200, 32'h300, 0, 1, 2'b01, 32'h200,  0,        0);
        vecs[4]  = mk("load_use",   1, 1, 3'b000, 2'b11, 5, 3, 7, 1, 0, 32'h100, 32'h200, 32'h300, 1, 0, 2'b10, 0,        32'h300,  0);
        vecs[5]  = mk("load_use2",  1, 1, 3'b000, 2'b11, 5, 3, 7, 1, 0, 32'h100, 32'hDEAD,32'h300, 0, 1, 2'b01, 32'hDEAD, RF1,      1);
        vecs[6]  = mk("shadow_a",   1, 1, 3'b000, 2'b01, 7, 0, 4, 1, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b01, 32'h100,  0,        1);
        vecs[7]  = mk("shadow_b",   1, 1, 3'b000, 2'b00, 0, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b00, 0,        0,        1);
        vecs[8]  = mk("shadow_c",   1, 1, 3'b000, 2'b00, 0, 0, 4, 1, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b00, 0,        0,        1);
        vecs[9]  = mk("shadow",     1, 1, 3'b000, 2'b01, 4, 0, 0, 1, 0, 32'hA,   32'h200, 32'hB,   0, 1, 2'b01, 32'hA,    0,        1);
        vecs[10] = mk("regzero",    1, 1, 3'b000, 2'b11, 0, 4, 6, 1, 1, 32'h100, 32'h200, 32'h300, 0, 1, 2'b10, 0,        32'h200,  1);
        vecs[11] = mk("flush",      0, 0, 3'b001, 2'b01, 1, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300, 0, 0, 2'b00, RF0,      0,        1);
        vecs[12] = mk("flush_use",  1, 1, 3'b000, 2'b01, 6, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300, 0, 1, 2'b00, RF0,      0,        1);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].vld, vecs[i].adv, vecs[i].fl, vecs[i].used, vecs[i].s0, vecs[i].s1,
                  vecs[i].dst, vecs[i].wen, vecs[i].lat, vecs[i].sd0, vecs[i].sd1, vecs[i].sd2);
            @(negedge clk);
            chk({vecs[i].name, ".stall"}, 32'(stall),     32'(vecs[i].e_stall));
            chk({vecs[i].name, ".issue"}, 32'(issue),     32'(vecs[i].e_issue));
            chk({vecs[i].name, ".hit"},   32'(fwd_hit),   32'(vecs[i].e_hit));
            chk({vecs[i].name, ".src0"},  src_data[31:0],  vecs[i].e_o0);
            chk({vecs[i].name, ".src1"},  src_data[63:32], vecs[i].e_o1);
            chk({vecs[i].name, ".cnt"},   stall_cnt,       vecs[i].e_cnt);
            next_cycle();
        end

        // Hold: lw r5 issues, then its consumer sits in ID with the pipe frozen.
        drive(1, 1, 3'b000, 2'b00, 0, 0, 5, 1, 1, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        chk("hold_prod.issue", 32'(issue), 32'd1);
        next_cycle();
        for (int n = 0; n < 3; n++) begin
            drive(1, 0, 3'b000, 2'b01, 5, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300);
            @(negedge clk);
            chk("hold.stall", 32'(stall), 32'd1);
            chk("hold.issue", 32'(issue), 32'd0);
            chk("hold.cnt",   stall_cnt,  32'd1 + 32'(n));
            next_cycle();
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.stall", 32'(stall), 32'd1);
        chk("rst_mid.cnt",   stall_cnt,  32'd4);
        next_cycle();
        rst = 1'b0;
        drive(1, 1, 3'b000, 2'b01, 5, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        chk("post_rst.stall", 32'(stall),      32'd0);
        chk("post_rst.cnt",   stall_cnt,       32'd0);
        chk("post_rst.src0",  src_data[31:0],  RF0);
        chk("post_rst.hit",   32'(fwd_hit),    32'd0);
        chk("post_rst.issue", 32'(issue),      32'd1);
        next_cycle();

        // Latency 3 clamps to 2: dependent waits two cycles, then reads WB data.
        drive(1, 1, 3'b000, 2'b00, 0, 0, 9, 1, 2'd3, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        chk("clamp_prod.issue", 32'(issue), 32'd1);
        next_cycle();
        for (int n = 0; n < 2; n++) begin
            drive(1, 1, 3'b000, 2'b01, 9, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300);
            @(negedge clk);
            chk("clamp.stall", 32'(stall), 32'd1);
            next_cycle();
        end
        drive(1, 1, 3'b000, 2'b01, 9, 0, 0, 0, 0, 32'h100, 32'h200, 32'h300);
        @(negedge clk);
        chk("clamp_use.stall", 32'(stall),     32'd0);
        chk("clamp_use.src0",  src_data[31:0], 32'h300);
        chk("clamp_use.hit",   32'(fwd_hit),   32'd1);
        chk("clamp_use.cnt",   stall_cnt,      32'd2);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
